// File: rtl/data_synchronizer_pkg.sv
// Shared definitions for the enable-qualified multi-bit CDC receiver.
package data_synchronizer_pkg;

  typedef enum logic {
    StIdle = 1'b0,
    StHold = 1'b1
  } sync_state_e;

  localparam int unsigned MinStageCount = 2;

endpackage

// File: rtl/data_sync_chain.sv
// STAGE_COUNT-deep single-bit synchronizer chain with async active-high reset.
module data_sync_chain #(
  parameter int unsigned STAGE_COUNT = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGE_COUNT-1:0] chain_q;

  // Pure flop-to-flop shift; no logic between stages.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[STAGE_COUNT-2:0], d};
    end
  end

  assign q = chain_q[STAGE_COUNT-1];

endmodule

// File: rtl/data_synchronizer.sv
// Destination-side receiver: synchronizes a level enable and captures the held bus once.
// Optional handshake level output enable_ack when DATA_SYNCHRONIZER_ACK_EN is defined.
module data_synchronizer
  import data_synchronizer_pkg::*;
#(
  parameter int unsigned          BUS_WIDTH   = 8,
  parameter int unsigned          STAGE_COUNT = 2,
  parameter logic [BUS_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BUS_WIDTH-1:0] unsynchronized_data,
  input  logic                 unsynchronized_enable,
  output logic [BUS_WIDTH-1:0] synchronous_data,
  output logic                 enable_pulse
`ifdef DATA_SYNCHRONIZER_ACK_EN
  ,
  output logic                 enable_ack
`endif
);

  if (STAGE_COUNT < MinStageCount) begin : gen_bad_stage_count
    $error("data_synchronizer: STAGE_COUNT must be at least %0d", MinStageCount);
  end

  logic        sync_enable;
  sync_state_e state_q;

  data_sync_chain #(
    .STAGE_COUNT(STAGE_COUNT)
  ) u_sync_chain (
    .clk  (clk),
    .reset(reset),
    .d    (unsynchronized_enable),
    .q    (sync_enable)
  );

  // The bus is only sampled on IDLE->HOLD, when the source guarantees it is stable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= StIdle;
      enable_pulse     <= 1'b0;
      synchronous_data <= RESET_VALUE;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (sync_enable) begin
            synchronous_data <= unsynchronized_data;
            enable_pulse     <= 1'b1;
            state_q          <= StHold;
          end else begin
            enable_pulse <= 1'b0;
          end
        end
        StHold: begin
          enable_pulse <= 1'b0;
          if (!sync_enable) begin
            state_q <= StIdle;
          end
        end
        default: begin
          enable_pulse <= 1'b0;
          state_q      <= StIdle;
        end
      endcase
    end
  end

`ifdef DATA_SYNCHRONIZER_ACK_EN
  logic ack_q;

  // Next state is HOLD exactly when sync_enable is high, so this tracks state_q.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ack_q <= 1'b0;
    end else begin
      ack_q <= sync_enable;
    end
  end

  assign enable_ack = ack_q;
`else
  // No handshake: the source honours the minimum enable-low time between transfers.
`endif

endmodule

// File: tb/tb_data_synchronizer.sv
// Directed self-checking bench for data_synchronizer (STAGE_COUNT 2 and 3 instances).
module tb_data_synchronizer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data_a, data_b;
  logic       en_a, en_b;
  logic [7:0] sdata_a, sdata_b;
  logic       pulse_a, pulse_b;
`ifdef DATA_SYNCHRONIZER_ACK_EN
  logic       ack_a, ack_b;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_synchronizer #(
    .BUS_WIDTH  (8),
    .STAGE_COUNT(2),
    .RESET_VALUE(8'hA5)
  ) u_dut (
    .clk                  (clk),
    .reset                (reset),
    .unsynchronized_data  (data_a),
    .unsynchronized_enable(en_a),
    .synchronous_data     (sdata_a),
    .enable_pulse         (pulse_a)
`ifdef DATA_SYNCHRONIZER_ACK_EN
    ,
    .enable_ack           (ack_a)
`endif
  );

  data_synchronizer #(
    .BUS_WIDTH  (8),
    .STAGE_COUNT(3),
    .RESET_VALUE(8'h00)
  ) u_dut3 (
    .clk                  (clk),
    .reset                (reset),
    .unsynchronized_data  (data_b),
    .unsynchronized_enable(en_b),
    .synchronous_data     (sdata_b),
    .enable_pulse         (pulse_b)
`ifdef DATA_SYNCHRONIZER_ACK_EN
    ,
    .enable_ack           (ack_b)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance one destination edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int          pulses;
  logic [7:0]  exp_data;
  logic [7:0]  slow_vals [3];

  initial begin
    reset  = 1'b1;
    data_a = 8'h00;
    en_a   = 1'b0;
    data_b = 8'h00;
    en_b   = 1'b0;
    slow_vals[0] = 8'h81;
    slow_vals[1] = 8'h42;
    slow_vals[2] = 8'h24;

    // Reset value
    #2;
    check_eq("reset_data", 32'(sdata_a), 32'h A5);
    check_eq("reset_pulse", 32'(pulse_a), 32'h0);
    step();
    step();
    reset = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      step();
      check_eq("idle_pulse", 32'(pulse_a), 32'h0);
      check_eq("idle_data", 32'(sdata_a), 32'hA5);
    end

    // Single transfer, bus change while in HOLD ignored
    data_a = 8'h3C;
    en_a   = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      step();
      check_eq("single_pulse", 32'(pulse_a), (e == 3) ? 32'h1 : 32'h0);
      check_eq("single_data", 32'(sdata_a), (e >= 3) ? 32'h3C : 32'hA5);
      if (e == 6) data_a = 8'hFF;
    end
    en_a = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      step();
      check_eq("single_tail_pulse", 32'(pulse_a), 32'h0);
      check_eq("single_tail_data", 32'(sdata_a), 32'h3C);
    end

    // Back-to-back with the minimum 3-cycle enable gap
    pulses = 0;
    for (int e = 1; e <= 16; e++) begin
      en_a   = (e <= 5 || e >= 9);
      data_a = (e <= 8) ? 8'h11 : 8'h22;
      step();
      if (pulse_a) pulses++;
      check_eq("b2b_pulse", 32'(pulse_a), (e == 3 || e == 11) ? 32'h1 : 32'h0);
      exp_data = (e >= 11) ? 8'h22 : ((e >= 3) ? 8'h11 : 8'h3C);
      check_eq("b2b_data", 32'(sdata_a), 32'(exp_data));
`ifdef DATA_SYNCHRONIZER_ACK_EN
      check_eq("b2b_ack", 32'(ack_a), ((e >= 3 && e <= 7) || e >= 11) ? 32'h1 : 32'h0);
`endif
    end
    check_eq("b2b_count", 32'(pulses), 32'd2);
    en_a = 1'b0;
    for (int e = 1; e <= 4; e++) step();
`ifdef DATA_SYNCHRONIZER_ACK_EN
    check_eq("ack_low", 32'(ack_a), 32'h0);
`endif

    // Slow source: enable toggles at 7x the destination period, 3-stage chain
    for (int t = 0; t < 3; t++) begin
      pulses = 0;
      for (int e = 1; e <= 14; e++) begin
        en_b   = (e <= 7);
        data_b = slow_vals[t];
        step();
        if (pulse_b) pulses++;
        check_eq("slow_pulse", 32'(pulse_b), (e == 4) ? 32'h1 : 32'h0);
        if (e >= 4) check_eq("slow_data", 32'(sdata_b), 32'(slow_vals[t]));
        if (e == 8) data_b = 8'hEE;
      end
      check_eq("slow_count", 32'(pulses), 32'd1);
    end
    en_b = 1'b0;

    // Reset while in HOLD with enable high, right after the capture edge
    data_a = 8'h5A;
    en_a   = 1'b1;
    for (int e = 1; e <= 3; e++) step();
    check_eq("pre_rst_pulse", 32'(pulse_a), 32'h1);
    check_eq("pre_rst_data", 32'(sdata_a), 32'h5A);
    reset = 1'b1;
    #1;
    check_eq("rst_async_pulse", 32'(pulse_a), 32'h0);
    check_eq("rst_async_data", 32'(sdata_a), 32'hA5);
    step();
    reset = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      step();
      check_eq("post_rst_pulse", 32'(pulse_a), (e == 3) ? 32'h1 : 32'h0);
      check_eq("post_rst_data", 32'(sdata_a), (e >= 3) ? 32'h5A : 32'hA5);
    end
    en_a = 1'b0;
    for (int e = 1; e <= 4; e++) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
